// File: rtl/eea_inv_ctrl.sv
// eea_inv_ctrl: step sequencer driving the GF(2^M) extended-Euclidean inversion cell array.
// Define EEA_ZERO_DET_EN to add the zero_err output, which flags a zero operand at done.
module eea_inv_ctrl #(
   parameter int M  = 8,
   parameter int DW = $clog2(2*M+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          r_top,
   input  logic          s_top,
   output logic          load_en,
   output logic          step_en,
   output logic          Switch,
   output logic          Reduce,
   output logic          MultR,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] delta
`ifdef EEA_ZERO_DET_EN
   ,
   output logic          zero_err
`endif
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   localparam logic [DW-1:0] L_MAX  = DW'(2*M);
   localparam logic [DW-1:0] L_LAST = DW'(2*M-1);
   state_t        r_state, w_next;
   logic [DW-1:0] r_delta, r_cnt, w_delta_nx;
   logic          w_run;
   // delta and cnt only live during RUN; they read as the final value in DONE and 0 elsewhere
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_delta <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_delta <= (r_state == RUN) ? w_delta_nx : (r_state == DONE) ? '0 : (r_state == LOAD) ? '0 : r_delta;
         r_cnt   <= (r_state == RUN) ? r_cnt + 1'b1 : '0;
      end
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (start ? LOAD : IDLE) :
               (r_state == LOAD) ? RUN :
               (r_state == RUN)  ? ((r_cnt == L_LAST) ? DONE : RUN) : IDLE;
      w_run   = (r_state == RUN);
      load_en = (r_state == LOAD);
      step_en = w_run;
      busy    = (r_state == LOAD) | w_run;
      done    = (r_state == DONE);
      MultR   = w_run & ~r_top;
      Reduce  = w_run & r_top & s_top;
      Switch  = w_run & r_top & (r_delta == '0);
      w_delta_nx = !r_top ? ((r_delta == L_MAX) ? r_delta : r_delta + 1'b1) :
                   (r_delta == '0) ? DW'(1) : r_delta - 1'b1;
   end
   assign delta = r_delta;
`ifdef EEA_ZERO_DET_EN
   logic r_seen_r;
   always_ff @(posedge clk) begin
      if (rst || r_state == LOAD) r_seen_r <= 1'b0;
      else if (r_state == RUN && r_top) r_seen_r <= 1'b1;
   end
   assign zero_err = done & ~r_seen_r;
`endif
endmodule

// File: tb/tb_eea_inv_ctrl.sv
// tb_eea_inv_ctrl: pairs the controller with a GF(2^4) cell-array model and checks inverses,
// control lines, delta trace and handshake timing.
module tb_eea_inv_ctrl;
   localparam int M  = 4;
   localparam int DW = $clog2(2*M+1);
   localparam logic [M:0] F = 5'b10011;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, r_top = 1'b0, s_top = 1'b0;
   logic load_en, step_en, Switch, Reduce, MultR, busy, done;
   logic [DW-1:0] delta;
`ifdef EEA_ZERO_DET_EN
   logic zero_err;
`endif
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   eea_inv_ctrl #(.M(M)) dut (
      .clk(clk), .rst(rst), .start(start), .r_top(r_top), .s_top(s_top),
      .load_en(load_en), .step_en(step_en), .Switch(Switch), .Reduce(Reduce),
      .MultR(MultR), .busy(busy), .done(done), .delta(delta)
`ifdef EEA_ZERO_DET_EN
      , .zero_err(zero_err)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [M:0] mulx(input logic [M:0] p);
      logic [M:0] t;
      t = p << 1;
      return t[M] ? t ^ F : t;
   endfunction
   function automatic logic [M:0] divx(input logic [M:0] p);
      return p[0] ? (p ^ F) >> 1 : p >> 1;
   endfunction
   function automatic logic [M:0] gf_mul(input logic [M:0] a, input logic [M:0] b);
      logic [M:0] r, x;
      r = '0;
      x = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) r ^= x;
         x = mulx(x);
      end
      return r;
   endfunction
   function automatic logic [M:0] inv_ref(input logic [M:0] a);
      for (int v = 1; v < (1 << M); v++)
         if (gf_mul(a, (M+1)'(v)) == (M+1)'(1)) return (M+1)'(v);
      return '0;
   endfunction
   // One inversion; R ~ A*P and S ~ A*Q (mod f) hold throughout, so when R ends at x^M
   // the inverse is P * x^-M.
   task automatic run_inv(input logic [M-1:0] a, input bit poke);
      logic [M:0] R, S, P, Q, t;
      logic rt;
      int d, dmax, steps;
      R = {1'b0, a}; S = F; P = 1; Q = 0; d = 0; dmax = 0; steps = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load_en", load_en, 1);
      chk("load_busy", busy, 1);
      chk("load_step", step_en, 0);
      chk("load_delta", delta, 0);
      tick();
      for (int i = 0; i < 2*M; i++) begin
         if (poke) start = (i == 2);
         r_top = R[M];
         s_top = S[M];
         #1;
         if (step_en) steps++;
         chk("run_busy", busy, 1);
         chk("run_done", done, 0);
         chk("run_load", load_en, 0);
         chk("run_delta", delta, d);
         chk("MultR", MultR, !R[M]);
         chk("Reduce", Reduce, R[M] & S[M]);
         chk("Switch", Switch, R[M] && d == 0);
         rt = R[M];
         if (MultR) begin
            R = R << 1;
            P = mulx(P);
         end else begin
            if (Reduce) begin
               S ^= R;
               Q ^= P;
            end
            S = S << 1;
            Q = mulx(Q);
            if (Switch) begin
               t = R; R = S; S = t;
               t = P; P = Q; Q = t;
            end
         end
         d = !rt ? ((d < 2*M) ? d + 1 : d) : (d == 0) ? 1 : d - 1;
         if (d > dmax) dmax = d;
         tick();
      end
      r_top = 1'b0;
      s_top = 1'b0;
      start = poke;
      #1;
      chk("steps", steps, 2*M);
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_step", step_en, 0);
      chk("done_ctrl", {Switch, Reduce, MultR}, 0);
      chk("final_delta", delta, d);
      chk("delta_max", dmax <= 2*M, 1);
`ifdef EEA_ZERO_DET_EN
      chk("zero_err", zero_err, a == 0);
`endif
      if (a != 0) begin
         repeat (M) P = divx(P);
         chk("R_final", R, 1 << M);
         chk("V_inverse", P, inv_ref({1'b0, a}));
      end
      tick();
      start = 1'b0;
      #1;
      chk("idle_load", load_en, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_delta", delta, 0);
   endtask
   initial begin
      int t_done[$];
      int ndone;
      rst = 1'b1;
      start = 1'b1;
      tick();
      chk("rst_outs", {load_en, step_en, Switch, Reduce, MultR, busy, done, delta}, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rel_outs", {load_en, step_en, Switch, Reduce, MultR, busy, done, delta}, 0);
      tick();
      chk("rel_load", load_en, 1);
      chk("rel_busy", busy, 1);
      start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_load_busy", busy, 0);
      chk("rst_load_en", load_en, 0);
      tick();
      run_inv(4'b0010, 1'b0);
      chk("x_inv_const", inv_ref(5'b00010), 5'b01001);
      run_inv(4'b0001, 1'b0);
      run_inv(4'b0010, 1'b1);
      start = 1'b1;
      for (int c = 0; c < 40 && t_done.size() < 2; c++) begin
         tick();
         if (done) t_done.push_back(c);
         if (t_done.size() == 2) start = 1'b0;
      end
      start = 1'b0;
      chk("b2b_count", t_done.size(), 2);
      if (t_done.size() == 2) chk("b2b_spacing", t_done[1] - t_done[0], 2*M + 3);
      tick();
      chk("b2b_idle", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("mid_delta_pre", delta, 2);
      chk("mid_step", step_en, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_delta", delta, 0);
      chk("mid_step_off", step_en, 0);
      ndone = 0;
      repeat (2*M + 4) begin
         tick();
         if (done || busy) ndone++;
      end
      chk("mid_no_done", ndone, 0);
      run_inv(4'b0000, 1'b0);
      repeat (8) begin
         repeat ($urandom_range(0, 3)) tick();
         run_inv(4'($urandom_range(1, (1 << M) - 1)), 1'($urandom_range(0, 1)));
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/eea_inv_ctrl.md
# eea_inv_ctrl

Sequencing controller for the extended-Euclidean GF(2^M) inversion array. It takes the top-bit observations of the R and S rows and drives the per-cell control lines `Switch`, `Reduce` and `MultR` for exactly 2·M steps. It also tracks the degree difference `delta` and runs a start/busy/done handshake toward the host. It sits between the host interface and the combinational row of bit-level inversion cells; the R/S/U/V state registers are external and are strobed by `load_en` and `step_en`.

## Interface
Parameters:
- `M`, default 8: field degree; the run length is 2·M steps.
- `DW`, default `$clog2(2*M+1)`: width of `delta` and of the step counter.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: begin an inversion; sampled only in IDLE.
- `r_top`, input, 1: current r_M, the coefficient of x^M in the R register.
- `s_top`, input, 1: current s_M, the coefficient of x^M in the S register.
- `load_en`, output, 1: load operand A into R and f into S (U=0, V=1).
- `step_en`, output, 1: capture the array outputs into the R/S/U/V registers.
- `Switch`, output, 1: cell control, swap the R and S roles.
- `Reduce`, output, 1: cell control, form S−R before the shift.
- `MultR`, output, 1: cell control, shift R up (R=x·R), S held.
- `busy`, output, 1: high from LOAD through the last RUN cycle.
- `done`, output, 1: one-cycle pulse; the result in V is valid.
- `delta`, output, DW: current degree difference, for debug and verification.

## Operation
States are IDLE, LOAD, RUN and DONE.
- **IDLE**: all outputs are 0. `start`=1 moves to LOAD.
- **LOAD** (1 cycle): `load_en`=1 and `busy`=1. On exit, `delta` is cleared to 0 and `cnt` to 0. Next state is RUN.
- **RUN** (exactly 2·M cycles): `step_en`=1 and `busy`=1. The cell controls are combinational from the registered `delta`, `r_top` and `s_top`:
  - `MultR` = ~`r_top`
  - `Reduce` = `r_top` & `s_top`
  - `Switch` = `r_top` & (`delta`==0)
- `delta` update on each RUN edge:
  - if `r_top`=0: `delta`+1
  - else if `delta`==0: `delta` ← 1
  - else: `delta`−1
- `cnt` increments on each RUN edge. When `cnt`==2·M−1, the next state is DONE.
- **DONE** (1 cycle): `done`=1, `busy`=0, controls are 0. Next state is IDLE.
- Arithmetic: `delta` never exceeds 2·M, because it rises by at most 1 per step over 2·M steps. The update saturates at 2·M and must not wrap. `delta` never goes below 0, because the decrement branch requires `delta`≠0.
- Boundary conditions:
  - `start` outside IDLE is ignored, including in DONE.
  - `start` held high restarts on the cycle after DONE returns to IDLE.
  - `rst` in any state returns to IDLE on that edge. All outputs, `delta` and `cnt` become 0, and a partial run is abandoned with no `done`.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `start` sampled at edge t gives `load_en` during cycle t+1 and `step_en` during cycles t+2 … t+2·M+1. `done` is high during cycle t+2·M+2.
- Total latency is start edge to `done` = 2·M+2 cycles. Minimum spacing between starts is 2·M+3 cycles.
- `r_top` and `s_top` must be stable before the edge. The controls are combinational, so there is a single-cycle path of register → `r_top` → controls → cell array → register.

## Configuration
- `EEA_ZERO_DET_EN`: when defined, adds an output `zero_err` (1 bit, reset 0).
  - A sticky flag `seen_r` clears in LOAD and sets on any RUN cycle with `r_top`=1.
  - `zero_err` is driven equal to `done` & ~`seen_r`. This flags A=0, which has no inverse.
- When the macro is undefined, the `zero_err` port and `seen_r` logic are absent and behaviour is otherwise identical.

## Test plan
- **Reset**: assert `rst` for 2 cycles with `start`=1 → all outputs 0 and `busy`=0 on the first cycle after release; LOAD begins the cycle after that.
- **M=4 inversion**: f=x^4+x+1, A=x, bench pairs the block with a cell-array model. Expected: `done` at start+10; V=x^3+1 (4'b1001); 8 `step_en` cycles; first RUN cycle drives `MultR`=1.
- **M=4, A=1**: V=1; `delta` trace is legal, never negative, max ≤8.
- **Busy/restart**: pulse `start` during RUN and during DONE → ignored and exactly one `done`. Hold `start` high → back-to-back runs spaced 11 cycles apart.
- **Mid-run reset**: `rst` at RUN step 3 → no `done`; next cycle IDLE with `delta`=0.
- **EEA_ZERO_DET_EN defined, A=0**: `zero_err`=1 with `done`. With A=x, `zero_err`=0.
